// File: rtl/layer_input_deserializer.sv
// layer_input_deserializer
// Collects a serial stream of WIDTH-bit activation words into N_IN-word
// frames and presents each complete frame as one wide parallel bus.
// Two banks are used ping-pong: while one bank is presented and held
// stable, the other bank fills. Word contents are never modified.
//
// Handshake rules (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   The producer may change data/valid/last freely while ready is 0; such
//   words are ignored. The deserializer never makes ready depend
//   combinationally on valid. On the output side, m_data is held constant
//   while m_valid=1 and m_ready=0. s_ready is derived only from registered
//   bank flags (and forced low during reset), so m_ready has no
//   combinational path to s_ready.
module layer_input_deserializer #(
   parameter int N_IN  = 15,
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        s_data,
   input  logic                    s_valid,
   input  logic                    s_last,
   output logic                    s_ready,
   output logic [N_IN*WIDTH-1:0]   m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    err_len,
   output logic [7:0]              drop_cnt
);

   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

   // Frame storage and bookkeeping
   logic [N_IN*WIDTH-1:0] r_bank [2];
   logic [1:0]            r_full;
   logic                  r_wr_bank;
   logic                  r_rd_bank;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_err_len;
   logic [7:0]            r_drop_cnt;

   logic                  w_accept;
   logic                  w_at_end;
   logic                  w_commit;
   logic                  w_short;
   logic                  w_release;
   logic [1:0]            w_full_nxt;

   // Input side is ready whenever the bank being filled is empty.
   assign s_ready   = !r_full[r_wr_bank] && !rst;
   assign w_accept  = s_valid && s_ready;
   assign w_at_end  = (r_idx == IDX_LAST);
   assign w_commit  = w_accept && w_at_end;
   assign w_short   = w_accept && !w_at_end && s_last;
   assign w_release = r_full[r_rd_bank] && m_ready;

   assign m_valid  = r_full[r_rd_bank];
   assign m_data   = r_bank[r_rd_bank];
   assign err_len  = r_err_len;
   assign drop_cnt = r_drop_cnt;

   // Next bank-full flags: commit and release always target different
   // banks (a committing bank was empty, a releasing bank is full), so
   // both can be applied in the same cycle.
   always_comb begin
      w_full_nxt = r_full;
      if (w_commit) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_release) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
   end

   // Flag, pointer, index and error/drop bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full     <= 2'b00;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_idx      <= '0;
         r_err_len  <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else begin
         r_full    <= w_full_nxt;
         r_err_len <= 1'b0;
         if (w_release) begin
            r_rd_bank <= ~r_rd_bank;
         end
         if (w_accept) begin
            if (w_at_end) begin
               // Full-length frame: commit even when s_last is missing,
               // but flag the length violation.
               r_wr_bank <= ~r_wr_bank;
               r_idx     <= '0;
               r_err_len <= ~s_last;
            end else if (s_last) begin
               // Short frame: discard, restart the same bank.
               r_idx     <= '0;
               r_err_len <= 1'b1;
               if (r_drop_cnt != 8'hFF) begin
                  r_drop_cnt <= r_drop_cnt + 8'd1;
               end
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   // Word write into the bank being filled; the presented bank is never
   // written because it is full, which keeps m_data stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bank[0] <= '0;
         r_bank[1] <= '0;
      end else if (w_accept) begin
         r_bank[r_wr_bank][int'(r_idx)*WIDTH +: WIDTH] <= s_data;
      end
   end

   // w_short is kept as a named term for checker binding.
   logic w_unused;
   assign w_unused = w_short;

endmodule

// File: tb/tb_layer_input_deserializer.sv
// Directed bench for layer_input_deserializer: reset, streaming,
// back-pressure with both banks full, short/long frames, mid-frame reset
// and drop counter saturation.
module tb_layer_input_deserializer;

   localparam int N_IN  = 15;
   localparam int WIDTH = 32;

   logic                  clk;
   logic                  rst;
   logic [WIDTH-1:0]      s_data;
   logic                  s_valid;
   logic                  s_last;
   logic                  s_ready;
   logic [N_IN*WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  err_len;
   logic [7:0]            drop_cnt;

   int n_vec;
   int n_err;
   int err_cnt;

   layer_input_deserializer #(.N_IN(N_IN), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .err_len  (err_len),
      .drop_cnt (drop_cnt)
   );

   // Clock generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count every cycle in which err_len is high.
   always @(negedge clk) begin
      if (err_len) err_cnt <= err_cnt + 1;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] d, input logic last);
      step();
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
   endtask

   task automatic idle();
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   function automatic logic [31:0] word_a(input int k);
      return m_data[k*WIDTH +: WIDTH];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      err_cnt = 0;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;

      // ---- reset state
      step(); step(); step();
      chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_drop",    {24'd0, drop_cnt}, 32'd0);
      chk("rst_err",     {31'd0, err_len}, 32'd0);
      chk("rst_a0",      word_a(0), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

      // ---- basic frame, consumer always ready
      m_ready = 1'b1;
      for (int k = 0; k < N_IN; k++) drive(32'h3F80_0000 + k, k == N_IN-1);
      chk("t1_no_valid_before_last", {31'd0, m_valid}, 32'd0);
      idle();
      chk("t1_valid",   {31'd0, m_valid}, 32'd1);
      chk("t1_a0",      word_a(0), 32'h3F80_0000);
      chk("t1_a14",     word_a(14), 32'h3F80_000E);
      chk("t1_err_cnt", err_cnt, 32'd0);
      step();
      chk("t1_released", {31'd0, m_valid}, 32'd0);
      m_ready = 1'b0;

      // ---- three frames back to back with consumer stalled
      for (int f = 1; f <= 2; f++)
         for (int k = 0; k < N_IN; k++) drive(32'h4000_0000 + f*256 + k, k == N_IN-1);
      step();
      s_valid = 1'b1; s_data = 32'h4000_0300; s_last = 1'b0;
      chk("t2_both_full_s_ready", {31'd0, s_ready}, 32'd0);
      chk("t2_valid",  {31'd0, m_valid}, 32'd1);
      chk("t2_f1_a0",  word_a(0), 32'h4000_0100);
      chk("t2_f1_a14", word_a(14), 32'h4000_010E);
      s_data = 32'hDEAD_BEEF;
      step();
      s_data = 32'h4000_0300;
      chk("t2_f1_stable", word_a(0), 32'h4000_0100);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("t2_f2_a0",      word_a(0), 32'h4000_0200);
      chk("t2_f2_a14",     word_a(14), 32'h4000_020E);
      chk("t2_s_ready_up", {31'd0, s_ready}, 32'd1);
      for (int k = 1; k < N_IN; k++) drive(32'h4000_0300 + k, k == N_IN-1);
      idle();
      chk("t2_full_again", {31'd0, s_ready}, 32'd0);
      chk("t2_f2_held",    word_a(0), 32'h4000_0200);
      m_ready = 1'b1;
      step();
      chk("t2_f3_a0",  word_a(0), 32'h4000_0300);
      chk("t2_f3_a14", word_a(14), 32'h4000_030E);
      step();
      m_ready = 1'b0;
      chk("t2_empty",    {31'd0, m_valid}, 32'd0);
      chk("t2_err_cnt",  err_cnt, 32'd0);

      // ---- short frame then good frame
      for (int k = 0; k < 5; k++) drive(32'h5500_0000 + k, k == 4);
      idle();
      chk("t3_err",     {31'd0, err_len}, 32'd1);
      chk("t3_drop",    {24'd0, drop_cnt}, 32'd1);
      chk("t3_m_valid", {31'd0, m_valid}, 32'd0);
      step();
      chk("t3_err_once", {31'd0, err_len}, 32'd0);
      for (int k = 0; k < N_IN; k++) drive(32'h5000_0000 + k, k == N_IN-1);
      idle();
      chk("t3_valid", {31'd0, m_valid}, 32'd1);
      chk("t3_a0",    word_a(0), 32'h5000_0000);
      chk("t3_a5",    word_a(5), 32'h5000_0005);
      chk("t3_a14",   word_a(14), 32'h5000_000E);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;

      // ---- full-length frame without s_last
      for (int k = 0; k < N_IN; k++) drive(32'h6000_0000 + k, 1'b0);
      idle();
      chk("t4_err",   {31'd0, err_len}, 32'd1);
      chk("t4_valid", {31'd0, m_valid}, 32'd1);
      chk("t4_drop",  {24'd0, drop_cnt}, 32'd1);
      chk("t4_a14",   word_a(14), 32'h6000_000E);
      step();
      chk("t4_err_once", {31'd0, err_len}, 32'd0);
      chk("t4_err_cnt",  err_cnt, 32'd2);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;

      // ---- reset mid-frame with a full bank pending
      for (int k = 0; k < N_IN; k++) drive(32'h7000_0000 + k, k == N_IN-1);
      for (int k = 0; k < 7; k++) drive(32'h7100_0000 + k, 1'b0);
      step();
      rst = 1'b1; s_valid = 1'b0;
      step();
      chk("t5_m_valid", {31'd0, m_valid}, 32'd0);
      chk("t5_drop",    {24'd0, drop_cnt}, 32'd0);
      chk("t5_err",     {31'd0, err_len}, 32'd0);
      chk("t5_a0_clr",  word_a(0), 32'd0);
      chk("t5_s_ready_in_rst", {31'd0, s_ready}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < N_IN; k++) drive(32'h7200_0000 + k, k == N_IN-1);
      idle();
      chk("t5_valid", {31'd0, m_valid}, 32'd1);
      chk("t5_a0",    word_a(0), 32'h7200_0000);
      chk("t5_a1",    word_a(1), 32'h7200_0001);
      chk("t5_a14",   word_a(14), 32'h7200_000E);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("t5_err_cnt", err_cnt, 32'd2);

      // ---- drop counter saturation
      for (int i = 0; i < 255; i++) drive(32'h8000_0000 + i, 1'b1);
      idle();
      chk("t6_drop_255", {24'd0, drop_cnt}, 32'd255);
      for (int i = 0; i < 45; i++) drive(32'h8100_0000 + i, 1'b1);
      idle();
      chk("t6_drop_sat", {24'd0, drop_cnt}, 32'd255);
      chk("t6_m_valid",  {31'd0, m_valid}, 32'd0);
      step();
      chk("t6_err_cnt",  err_cnt, 32'd302);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
